reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 159 +++++++++++++++
 tb/tb_reset_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// ----------------------------------------------------------------------------
// reset_sequencer
//
// Staged reset release for the memory, bus and CPU domains. All domains are
// held in reset for HOLD_CYCLES edges after the last reset event, then
// released in the order mem -> bus -> cpu with STAGE_GAP edges between
// successive releases. Software-reset and watchdog requests re-run the whole
// sequence. The cause of the last sequence is kept for software readback.
//
// State table
//   state | seq_state_o | meaning
//   HOLD  | 00          | all domains in reset, counting the hold time
//   MEM   | 01          | memory released, bus and cpu still in reset
//   BUS   | 10          | memory and bus released, cpu still in reset
//   RUN   | 11          | all domains released, ready_o high
//
// Ports
//   clk_i           in   PLL output clock, rising edge
//   reset_i         in   SoC-level synchronized reset, sync active-high
//   sw_reset_req_i  in   software reset request (pulse or level)
//   wdt_expire_i    in   watchdog expiry request (pulse or level)
//   rst_mem_o       out  memory-domain reset, active-high
//   rst_bus_o       out  bus/interconnect reset, active-high
//   rst_cpu_o       out  CPU reset, active-high
//   ready_o         out  high only when all domains are released
//   reset_cause_o   out  01 external/PLL, 10 software, 11 watchdog
//   seq_state_o     out  current sequencer state (see table)
// ----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       sw_reset_req_i,
  input  logic       wdt_expire_i,
  output logic       rst_mem_o,
  output logic       rst_bus_o,
  output logic       rst_cpu_o,
  output logic       ready_o,
  output logic [1:0] reset_cause_o,
  output logic [1:0] seq_state_o
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(CNT_MAX - 1);

  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

  generate
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_bad_gap
      $error("reset_sequencer: STAGE_GAP must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_MEM  = 2'b01,
    ST_BUS  = 2'b10,
    ST_RUN  = 2'b11
  } state_t;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [1:0]       cause_q, cause_nxt;
  logic             req_event;

  assign req_event = sw_reset_req_i | wdt_expire_i;

  // Next-state logic. reset_i is handled in the register process since it
  // overrides everything here. A held request keeps re-entering HOLD with a
  // cleared counter, so the hold time is measured from its last edge.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    cause_nxt = cause_q;

    if (req_event) begin
      state_nxt = ST_HOLD;
      cnt_nxt   = '0;
      cause_nxt = wdt_expire_i ? CAUSE_WDT : CAUSE_SW;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_nxt = ST_MEM;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        ST_MEM: begin
          if (cnt_q == GAP_LAST) begin
            state_nxt = ST_BUS;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        ST_BUS: begin
          if (cnt_q == GAP_LAST) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          cnt_nxt = '0;
        end
        default: begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counter and output registers. The reset outputs are decoded from
  // the next state and registered, so they change at the same edge as the
  // state and never see a combinational path from the inputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      cause_q   <= CAUSE_EXT;
      rst_mem_o <= 1'b1;
      rst_bus_o <= 1'b1;
      rst_cpu_o <= 1'b1;
      ready_o   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      cause_q   <= cause_nxt;
      rst_mem_o <= (state_nxt == ST_HOLD);
      rst_bus_o <= (state_nxt == ST_HOLD) || (state_nxt == ST_MEM);
      rst_cpu_o <= (state_nxt != ST_RUN);
      ready_o   <= (state_nxt == ST_RUN);
    end
  end

  assign reset_cause_o = cause_q;
  assign seq_state_o   = state_q;

  // The counter only ever counts up to the terminal value of the current
  // stage, so it can never pass the larger of the two terminal counts.
  a_cnt_bound : assert property (@(posedge clk_i) disable iff (reset_i)
                                 cnt_q <= CNT_LIMIT);

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       sw_reset_req_i = 1'b0;
  logic       wdt_expire_i = 1'b0;

  logic       rst_mem, rst_bus, rst_cpu, ready;
  logic [1:0] cause, state;
  logic       f_rst_mem, f_rst_bus, f_rst_cpu, f_ready;
  logic [1:0] f_cause, f_state;

  always #5 clk_i = ~clk_i;

  reset_sequencer dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .sw_reset_req_i (sw_reset_req_i),
    .wdt_expire_i   (wdt_expire_i),
    .rst_mem_o      (rst_mem),
    .rst_bus_o      (rst_bus),
    .rst_cpu_o      (rst_cpu),
    .ready_o        (ready),
    .reset_cause_o  (cause),
    .seq_state_o    (state)
  );

  reset_sequencer #(.HOLD_CYCLES(1), .STAGE_GAP(1)) dut_fast (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .sw_reset_req_i (sw_reset_req_i),
    .wdt_expire_i   (wdt_expire_i),
    .rst_mem_o      (f_rst_mem),
    .rst_bus_o      (f_rst_bus),
    .rst_cpu_o      (f_rst_cpu),
    .ready_o        (f_ready),
    .reset_cause_o  (f_cause),
    .seq_state_o    (f_state)
  );

  // {mem, bus, cpu, ready, cause[1:0], state[1:0]}
  logic [7:0] dut_vec, fast_vec;
  assign dut_vec  = {rst_mem, rst_bus, rst_cpu, ready, cause, state};
  assign fast_vec = {f_rst_mem, f_rst_bus, f_rst_cpu, f_ready, f_cause, f_state};

  int total = 0;
  int bad   = 0;

  // Reference model: edges elapsed since the last reset event and its cause.
  int         since = 1000;
  logic [1:0] m_cause = 2'b00;

  function automatic logic [7:0] exp_vec(input int s, input logic [1:0] c,
                                         input int h, input int g);
    logic m, b, p;
    logic [1:0] st;
    m = (s < h);
    b = (s < h + g);
    p = (s < h + 2 * g);
    st = m ? 2'b00 : b ? 2'b01 : p ? 2'b10 : 2'b11;
    return {m, b, p, ~p, c, st};
  endfunction

  task automatic check_vec(input string name, input logic [7:0] act,
                           input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (mem,bus,cpu,rdy,cause,state) t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One clock edge with the given inputs; model updated, both DUTs compared.
  task automatic step(input logic r, input logic s, input logic w);
    reset_i        = r;
    sw_reset_req_i = s;
    wdt_expire_i   = w;
    @(posedge clk_i);
    if (r) begin
      since = 0; m_cause = 2'b01;
    end else if (w) begin
      since = 0; m_cause = 2'b11;
    end else if (s) begin
      since = 0; m_cause = 2'b10;
    end else if (since < 1000) begin
      since++;
    end
    #1;
    check_vec("model_default", dut_vec, exp_vec(since, m_cause, 16, 4));
    check_vec("model_fast", fast_vec, exp_vec(since, m_cause, 1, 1));
  endtask

  typedef struct {
    logic       rst;
    logic       sw;
    logic       wdt;
    int         reps;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int fm, fb, fr;
    logic r, s, w;
    int  x;

    tbl[0]  = '{1'b1, 1'b0, 1'b0,  5, 8'b1110_01_00};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 15, 8'b1110_01_00};
    tbl[2]  = '{1'b0, 1'b0, 1'b0,  1, 8'b0110_01_01};
    tbl[3]  = '{1'b0, 1'b0, 1'b0,  3, 8'b0110_01_01};
    tbl[4]  = '{1'b0, 1'b0, 1'b0,  1, 8'b0010_01_10};
    tbl[5]  = '{1'b0, 1'b0, 1'b0,  3, 8'b0010_01_10};
    tbl[6]  = '{1'b0, 1'b0, 1'b0,  1, 8'b0001_01_11};
    tbl[7]  = '{1'b0, 1'b0, 1'b0,  5, 8'b0001_01_11};
    tbl[8]  = '{1'b0, 1'b1, 1'b0,  1, 8'b1110_10_00};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 16, 8'b0110_10_01};
    tbl[10] = '{1'b0, 1'b1, 1'b1,  1, 8'b1110_11_00};
    tbl[11] = '{1'b1, 1'b0, 1'b1,  1, 8'b1110_01_00};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 20, 8'b0010_01_10};
    tbl[13] = '{1'b0, 1'b1, 1'b0,  1, 8'b1110_10_00};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 10, 8'b1110_11_00};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 15, 8'b1110_11_00};
    tbl[16] = '{1'b0, 1'b0, 1'b0,  1, 8'b0110_11_01};
    tbl[17] = '{1'b0, 1'b0, 1'b0,  8, 8'b0001_11_11};

    for (int i = 0; i < 18; i++) begin
      for (int k = 0; k < tbl[i].reps; k++)
        step(tbl[i].rst, tbl[i].sw, tbl[i].wdt);
      check_vec($sformatf("table_row_%0d", i), dut_vec, tbl[i].exp);
    end

    // Single-cycle software request from RUN: measure release edges.
    step(1'b0, 1'b1, 1'b0);
    check_vec("sw_from_run", dut_vec, 8'b1110_10_00);
    fm = -1; fb = -1; fr = -1;
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (fm < 0 && rst_mem == 1'b0) fm = k;
      if (fb < 0 && rst_bus == 1'b0) fb = k;
      if (fr < 0 && ready == 1'b1)   fr = k;
    end
    check_int("sw_mem_release_edge", fm, 16);
    check_int("sw_bus_release_edge", fb, 20);
    check_int("sw_ready_edge", fr, 24);

    // Minimum parameters: one edge per stage after reset_i drops.
    step(1'b1, 1'b0, 1'b0);
    check_vec("fast_e0", fast_vec, 8'b1110_01_00);
    step(1'b0, 1'b0, 1'b0);
    check_vec("fast_e1", fast_vec, 8'b0110_01_01);
    step(1'b0, 1'b0, 1'b0);
    check_vec("fast_e2", fast_vec, 8'b0010_01_10);
    step(1'b0, 1'b0, 1'b0);
    check_vec("fast_e3", fast_vec, 8'b0001_01_11);

    // Randomized traffic with sparse events and occasional held levels.
    for (int n = 0; n < 1500; n++) begin
      x = $urandom_range(0, 199);
      r = (x < 2);
      s = (x >= 2 && x < 5);
      w = (x >= 5 && x < 7);
      if (x == 199) begin
        for (int k = 0; k < $urandom_range(2, 6); k++) step(1'b0, 1'b1, 1'b0);
      end else begin
        step(r, s, w);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
